control_unit: RTL and testbench
===============================

# control_unit

Microcoded sequencer for the 8-bit CPU. It sits directly downstream of the instruction register and consumes its 8-bit `instruction_out`. It steps fixed T-states (fetch, then per-opcode execute) and drives every load, enable and output-enable control line on the shared bus, including `load_ir` back into the instruction register.

## Interface
- No parameters; opcode and state encodings come from `defines.vh`.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `instruction`  in  8  IR contents; [7:4] opcode, [3:0] operand/address.
- `carry_flag`, `zero_flag`  in  1 each  registered ALU flags.
- `pc_out`, `pc_inc`, `pc_load`  out  1 each  PC drive bus / increment / load from bus.
- `mar_load`  out  1  MAR load from bus.
- `ram_out`, `ram_write`  out  1 each  RAM drive bus / write from bus.
- `load_ir`  out  1  IR load enable.
- `ir_out`  out  1  drive `instruction[3:0]` (zero-extended) on bus.
- `a_load`, `a_out`, `b_load`  out  1 each  register A load/drive, register B load.
- `alu_out`, `alu_sub`, `flags_load`  out  1 each  ALU drive bus, subtract select, flag capture.
- `out_load`  out  1  output register load.
- `halted`  out  1  high in HALT state.
- `t_state`  out  3  current step (0–4), or 7 in HALT; for debug/verification.

## Operation
States: T0, T1, T2, T3, T4, HALT. The fetch steps are the same for every instruction:
- **T0:** `pc_out`, `mar_load`.
- **T1:** `ram_out`, `load_ir`, `pc_inc`.

The opcode is decoded from T2 onward, using the IR value loaded at the end of T1. The last listed step of each instruction returns to T0 on the next edge; there are no dead cycles.
- **0x0 NOP:** T2 empty.
- **0x1 LDA:** T2 `ir_out`+`mar_load`; T3 `ram_out`+`a_load`.
- **0x2 ADD:** T2 `ir_out`+`mar_load`; T3 `ram_out`+`b_load`; T4 `alu_out`+`a_load`+`flags_load`.
- **0x3 SUB:** as ADD, with `alu_sub`=1 in T4 only.
- **0x4 STA:** T2 `ir_out`+`mar_load`; T3 `a_out`+`ram_write`.
- **0x5 LDI:** T2 `ir_out`+`a_load`.
- **0x6 JMP:** T2 `ir_out`+`pc_load`.
- **0x7 JC:** T2 `ir_out`; `pc_load` only if `carry_flag`=1, with the flag sampled in T2.
- **0x8 JZ:** as JC, using `zero_flag`.
- **0xE OUT:** T2 `a_out`+`out_load`.
- **0xF HLT:** T2 no controls asserted; next state HALT.
- **0x9–0xD:** treated as NOP.

HALT: all controls are 0 and `halted`=1. Only `reset` leaves HALT.

Invariants:
- At most one of `pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out` is high in any cycle.
- `ram_write` and `ram_out` are never both high.

## Timing
- Reset: state is forced to T0 asynchronously. While `reset` is high, every control output, `halted`, and `t_state` are forced to 0.
- The first T0 control pattern appears in the cycle after `reset` deasserts.
- Control outputs are combinational decodes of the registered state plus `instruction` and the flags. Consumers capture on the next rising edge.
- Instruction lengths in cycles:
  - 3: NOP, LDI, JMP, JC, JZ, OUT, and HLT (HLT then holds in HALT).
  - 4: LDA, STA.
  - 5: ADD, SUB.
- Reset asserted mid-instruction aborts it immediately. No partial step completes after assertion.
- Flag changes during T0/T1 have no effect. JC/JZ use only the T2 values.
- PC wrap (0xF→0x0) is the PC's responsibility. The sequencer needs no special handling.

## Structure
- `defines.vh` gains:
  - opcode constants (`OP_NOP` … `OP_HLT`);
  - state encodings (`T0`–`T4`, `HALT` = 3'd7);
  - the control-word bit index constants.
- Internally, a 15-bit control word is produced by one combinational sub-module, `control_decode` (inputs: state, opcode, flags). `control_unit` holds only the state register and next-state logic, and fans out the control word.

## Test plan
- Reset release with IR=0x00: T0 shows `pc_out`=`mar_load`=1; T1 shows `ram_out`=`load_ir`=`pc_inc`=1; T2 shows no controls; back to T0 after exactly 3 cycles.
- IR=0x2A (ADD 0xA): T2 `ir_out`+`mar_load`, T3 `ram_out`+`b_load`, T4 `alu_out`+`a_load`+`flags_load` with `alu_sub`=0. With IR=0x3A, T4 has `alu_sub`=1. Each is 5 cycles total.
- JZ 0x4 (IR=0x84) with `zero_flag`=0: no `pc_load` in T2. With `zero_flag`=1: `pc_load`=`ir_out`=1 in T2. Toggling the flag during T0/T1 has no effect on either result.
- IR=0xF0: `halted`=1 and `t_state`=7 from the cycle after T2, holding for 20+ cycles with all controls 0. Asserting `reset` clears `halted` asynchronously, and T0 follows release.
- Assert `reset` in T3 of STA (IR=0x45): `ram_write` drops in the same cycle, without waiting for a clock edge. After release, fetch restarts at T0.
- All 16 opcodes run back-to-back: assert the single-bus-driver and no-read-while-write invariants every cycle. Opcodes 0x9–0xD must produce the NOP pattern.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the CPU sequencer: opcodes, T-state encodings and
// control-word bit positions.
package control_unit_pkg;

  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StHalt = 3'd7
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam int unsigned CwPcOut     = 0;
  localparam int unsigned CwPcInc     = 1;
  localparam int unsigned CwPcLoad    = 2;
  localparam int unsigned CwMarLoad   = 3;
  localparam int unsigned CwRamOut    = 4;
  localparam int unsigned CwRamWrite  = 5;
  localparam int unsigned CwLoadIr    = 6;
  localparam int unsigned CwIrOut     = 7;
  localparam int unsigned CwALoad     = 8;
  localparam int unsigned CwAOut      = 9;
  localparam int unsigned CwBLoad     = 10;
  localparam int unsigned CwAluOut    = 11;
  localparam int unsigned CwAluSub    = 12;
  localparam int unsigned CwFlagsLoad = 13;
  localparam int unsigned CwOutLoad   = 14;
  localparam int unsigned CwWidth     = 15;

  typedef logic [CwWidth-1:0] cword_t;

  // Index of the final T-state of an instruction; unlisted opcodes behave as NOP.
  function automatic logic [2:0] last_step(input logic [3:0] op);
    logic [2:0] step;
    case (op)
      OpLda, OpSta: step = 3'd3;
      OpAdd, OpSub: step = 3'd4;
      default:      step = 3'd2;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-word decode from the current T-state, opcode and flags.
module control_decode
  import control_unit_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output cword_t     cword
);

  always_comb begin
    cword = '0;
    unique case (state)
      StT0: begin
        cword[CwPcOut]   = 1'b1;
        cword[CwMarLoad] = 1'b1;
      end
      StT1: begin
        cword[CwRamOut] = 1'b1;
        cword[CwLoadIr] = 1'b1;
        cword[CwPcInc]  = 1'b1;
      end
      StT2: begin
        case (opcode)
          OpLda, OpAdd, OpSub, OpSta: begin
            cword[CwIrOut]   = 1'b1;
            cword[CwMarLoad] = 1'b1;
          end
          OpLdi: begin
            cword[CwIrOut] = 1'b1;
            cword[CwALoad] = 1'b1;
          end
          OpJmp: begin
            cword[CwIrOut]  = 1'b1;
            cword[CwPcLoad] = 1'b1;
          end
          // Conditional jumps keep driving the bus even when not taken.
          OpJc: begin
            cword[CwIrOut]  = 1'b1;
            cword[CwPcLoad] = carry_flag;
          end
          OpJz: begin
            cword[CwIrOut]  = 1'b1;
            cword[CwPcLoad] = zero_flag;
          end
          OpOut: begin
            cword[CwAOut]    = 1'b1;
            cword[CwOutLoad] = 1'b1;
          end
          default: ;
        endcase
      end
      StT3: begin
        case (opcode)
          OpLda: begin
            cword[CwRamOut] = 1'b1;
            cword[CwALoad]  = 1'b1;
          end
          OpAdd, OpSub: begin
            cword[CwRamOut] = 1'b1;
            cword[CwBLoad]  = 1'b1;
          end
          OpSta: begin
            cword[CwAOut]     = 1'b1;
            cword[CwRamWrite] = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        if (opcode == OpAdd || opcode == OpSub) begin
          cword[CwAluOut]    = 1'b1;
          cword[CwALoad]     = 1'b1;
          cword[CwFlagsLoad] = 1'b1;
          cword[CwAluSub]    = (opcode == OpSub);
        end
      end
      StHalt: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcoded T-state sequencer: holds the step register, chooses the next step
// and fans the decoded control word out onto the bus control lines.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instruction,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_write,
  output logic       load_ir,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] t_state
);

  state_e     state_q, state_d;
  cword_t     cword, cword_gated;
  logic [3:0] opcode;
  logic       unused_operand;

  assign opcode         = instruction[7:4];
  assign unused_operand = ^instruction[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StT0;
    unique case (state_q)
      StT0: state_d = StT1;
      StT1: state_d = StT2;
      StT2: begin
        if (opcode == OpHlt) begin
          state_d = StHalt;
        end else if (last_step(opcode) == 3'd2) begin
          state_d = StT0;
        end else begin
          state_d = StT3;
        end
      end
      StT3:    state_d = (last_step(opcode) == 3'd4) ? StT4 : StT0;
      StT4:    state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StT0;
    endcase
  end

  control_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .cword      (cword)
  );

  // Reset silences the bus combinationally so an aborted step cannot finish.
  assign cword_gated = reset ? '0 : cword;

  assign pc_out     = cword_gated[CwPcOut];
  assign pc_inc     = cword_gated[CwPcInc];
  assign pc_load    = cword_gated[CwPcLoad];
  assign mar_load   = cword_gated[CwMarLoad];
  assign ram_out    = cword_gated[CwRamOut];
  assign ram_write  = cword_gated[CwRamWrite];
  assign load_ir    = cword_gated[CwLoadIr];
  assign ir_out     = cword_gated[CwIrOut];
  assign a_load     = cword_gated[CwALoad];
  assign a_out      = cword_gated[CwAOut];
  assign b_load     = cword_gated[CwBLoad];
  assign alu_out    = cword_gated[CwAluOut];
  assign alu_sub    = cword_gated[CwAluSub];
  assign flags_load = cword_gated[CwFlagsLoad];
  assign out_load   = cword_gated[CwOutLoad];

  assign halted  = !reset && (state_q == StHalt);
  assign t_state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model queues the
// expected per-cycle control pattern, a negedge monitor pops and compares.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instruction = 8'h00;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_write, load_ir, ir_out;
  logic       a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted;
  logic [2:0] t_state;

  always #5 clk = ~clk;

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .pc_out      (pc_out),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .mar_load    (mar_load),
    .ram_out     (ram_out),
    .ram_write   (ram_write),
    .load_ir     (load_ir),
    .ir_out      (ir_out),
    .a_load      (a_load),
    .a_out       (a_out),
    .b_load      (b_load),
    .alu_out     (alu_out),
    .alu_sub     (alu_sub),
    .flags_load  (flags_load),
    .out_load    (out_load),
    .halted      (halted),
    .t_state     (t_state)
  );

  // Bench-local control line masks.
  localparam logic [14:0] MPcOut  = 15'h0001;
  localparam logic [14:0] MPcInc  = 15'h0002;
  localparam logic [14:0] MPcLd   = 15'h0004;
  localparam logic [14:0] MMar    = 15'h0008;
  localparam logic [14:0] MRamOut = 15'h0010;
  localparam logic [14:0] MRamWr  = 15'h0020;
  localparam logic [14:0] MLdIr   = 15'h0040;
  localparam logic [14:0] MIrOut  = 15'h0080;
  localparam logic [14:0] MALd    = 15'h0100;
  localparam logic [14:0] MAOut   = 15'h0200;
  localparam logic [14:0] MBLd    = 15'h0400;
  localparam logic [14:0] MAluOut = 15'h0800;
  localparam logic [14:0] MAluSub = 15'h1000;
  localparam logic [14:0] MFlags  = 15'h2000;
  localparam logic [14:0] MOutLd  = 15'h4000;

  logic [14:0] cw_act;
  assign cw_act = {out_load, flags_load, alu_sub, alu_out, b_load, a_out, a_load, ir_out,
                   load_ir, ram_write, ram_out, mar_load, pc_load, pc_inc, pc_out};

  typedef struct packed {
    logic [14:0] cw;
    logic        halted;
    logic [2:0]  t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endfunction

  // Per-cycle expected control words for one instruction, fetch included.
  function automatic void model(input logic [7:0] ir, input logic c, input logic z,
                                output logic [14:0] seq[$]);
    logic [3:0] op;
    op  = ir[7:4];
    seq = {};
    seq.push_back(MPcOut | MMar);
    seq.push_back(MRamOut | MLdIr | MPcInc);
    case (op)
      4'h1: begin seq.push_back(MIrOut | MMar); seq.push_back(MRamOut | MALd); end
      4'h2: begin
        seq.push_back(MIrOut | MMar); seq.push_back(MRamOut | MBLd);
        seq.push_back(MAluOut | MALd | MFlags);
      end
      4'h3: begin
        seq.push_back(MIrOut | MMar); seq.push_back(MRamOut | MBLd);
        seq.push_back(MAluOut | MALd | MFlags | MAluSub);
      end
      4'h4: begin seq.push_back(MIrOut | MMar); seq.push_back(MAOut | MRamWr); end
      4'h5: seq.push_back(MIrOut | MALd);
      4'h6: seq.push_back(MIrOut | MPcLd);
      4'h7: seq.push_back(MIrOut | (c ? MPcLd : 15'h0));
      4'h8: seq.push_back(MIrOut | (z ? MPcLd : 15'h0));
      4'hE: seq.push_back(MAOut | MOutLd);
      default: seq.push_back(15'h0);
    endcase
  endfunction

  task automatic push(input logic [14:0] cw, input logic h, input logic [2:0] t);
    exp_t e;
    e.cw = cw; e.halted = h; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      reset = 1'b1;
      instruction = 8'($urandom);
      carry_flag = 1'($urandom);
      zero_flag = 1'($urandom);
      push(15'h0, 1'b0, 3'd0);
    end
  endtask

  // Flags are random except in T2; IR is random in T0/T1 since it must not matter there.
  task automatic run_instr(input logic [7:0] ir, input logic c, input logic z,
                           input int abort_after);
    logic [14:0] seq[$];
    model(ir, c, z, seq);
    for (int k = 0; k < seq.size(); k++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      instruction = (k < 2) ? 8'($urandom) : ir;
      if (k == 2) begin
        carry_flag = c; zero_flag = z;
      end else begin
        carry_flag = 1'($urandom); zero_flag = 1'($urandom);
      end
      push(seq[k], 1'b0, 3'(k));
      if (k == abort_after) return;
    end
  endtask

  task automatic hold_halt(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      instruction = 8'($urandom);
      carry_flag = 1'($urandom);
      zero_flag = 1'($urandom);
      push(15'h0, 1'b1, 3'd7);
    end
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk({tag, "_ctrl"}, 32'(cw_act), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_t_state"}, 32'(t_state), 32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'h1, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ctrl_word", 32'(cw_act), 32'(mon_e.cw));
        chk("halted", 32'(halted), 32'(mon_e.halted));
        chk("t_state", 32'(t_state), 32'(mon_e.t));
      end
      chk("single_bus_driver",
          32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'h1);
      chk("no_read_while_write", 32'(ram_out & ram_write), 32'h0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    reset_cycles(3);
    run_instr(8'h00, 1'b0, 1'b0, -1);
    run_instr(8'h2A, 1'($urandom), 1'($urandom), -1);
    run_instr(8'h3A, 1'($urandom), 1'($urandom), -1);
    run_instr(8'h84, 1'b1, 1'b0, -1);
    run_instr(8'h84, 1'b0, 1'b1, -1);
    run_instr(8'h7C, 1'b1, 1'b0, -1);
    run_instr(8'h7C, 1'b0, 1'b1, -1);
    for (int o = 0; o < 15; o++) begin
      run_instr({4'(o), 4'($urandom)}, 1'($urandom), 1'($urandom), -1);
    end
    repeat (150) begin
      op = 4'($urandom_range(0, 14));
      run_instr({op, 4'($urandom)}, 1'($urandom), 1'($urandom), -1);
    end

    run_instr(8'hF0, 1'($urandom), 1'($urandom), -1);
    hold_halt(25);
    async_reset_check("halt_reset");
    reset_cycles(2);
    run_instr(8'h00, 1'b0, 1'b0, -1);

    run_instr(8'h45, 1'b0, 1'b0, 3);
    async_reset_check("sta_abort");
    reset_cycles(2);
    run_instr(8'h45, 1'b0, 1'b0, -1);
    run_instr(8'h2A, 1'b0, 1'b0, -1);

    repeat (40) begin
      op = 4'($urandom);
      run_instr({op, 4'($urandom)}, 1'($urandom), 1'($urandom), -1);
      if (op == 4'hF) begin
        hold_halt(int'($urandom_range(3, 8)));
        async_reset_check("rand_halt_reset");
        reset_cycles(1);
      end
    end

    @(negedge clk); #2;
    mon_en = 1'b0;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
